// File: rtl/core_mem_pkg.sv
// core_mem_pkg: shared definitions for the core_mem_access load/store front end.
//   - request size encodings
//   - FSM state type
//   - lane-mask constants and the size -> base mask helper
package core_mem_pkg;

    localparam logic [1:0] SIZE_BYTE    = 2'd0;
    localparam logic [1:0] SIZE_HALF    = 2'd1;
    localparam logic [1:0] SIZE_WORD    = 2'd2;
    localparam logic [1:0] SIZE_ILLEGAL = 2'd3;

    // 7-bit masks so a word access at offset 3 still fits after the shift.
    localparam logic [6:0] MASK_BYTE = 7'b000_0001;
    localparam logic [6:0] MASK_HALF = 7'b000_0011;
    localparam logic [6:0] MASK_WORD = 7'b000_1111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_ISSUE2,
        ST_WAIT2,
        ST_RESP
    } state_e;

    function automatic logic [6:0] lane_mask(input logic [1:0] size);
        case (size)
            SIZE_BYTE: lane_mask = MASK_BYTE;
            SIZE_HALF: lane_mask = MASK_HALF;
            SIZE_WORD: lane_mask = MASK_WORD;
            default:   lane_mask = 7'b000_0000;
        endcase
    endfunction

endpackage

// File: rtl/core_mem_align.sv
// core_mem_align: combinational lane logic for core_mem_access.
//   off_i     byte offset within the word
//   size_i    access size encoding
//   signed_i  sign-extend the load result
//   wdata_i   right-justified store data
//   low_i     first (lower) read word
//   high_i    second (upper) read word, zero when the access is not split
//   mask_o    7-bit byte-lane mask spanning two words
//   data64_o  store data positioned across two words
//   split_o   access needs a second transfer
//   rdata_o   recombined, extended load result
module core_mem_align
    import core_mem_pkg::*;
(
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] low_i,
    input  logic [31:0] high_i,
    output logic [6:0]  mask_o,
    output logic [63:0] data64_o,
    output logic        split_o,
    output logic [31:0] rdata_o
);

    logic [5:0]  shamt;
    logic [31:0] shifted;

    assign shamt    = {off_i, 3'b000};
    assign mask_o   = lane_mask(size_i) << off_i;
    assign data64_o = {32'h0, wdata_i} << shamt;
    assign split_o  = |mask_o[6:4];
    assign shifted  = 32'({high_i, low_i} >> shamt);

    always_comb begin
        rdata_o = 32'h0;
        case (size_i)
            SIZE_BYTE: rdata_o = signed_i ? {{24{shifted[7]}}, shifted[7:0]}
                                          : {24'h0, shifted[7:0]};
            SIZE_HALF: rdata_o = signed_i ? {{16{shifted[15]}}, shifted[15:0]}
                                          : {16'h0, shifted[15:0]};
            SIZE_WORD: rdata_o = shifted;
            default:   rdata_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/core_mem_access.sv
// core_mem_access: load/store front end of the ExperiarCore data path.
// Converts byte/half/word requests at any byte address into word-aligned
// single transfers; accesses straddling a word boundary become two
// back-to-back transfers. Load data is recombined and extended.
//   wb_clk_i / wb_rst_n_i          clock, async active-low reset
//   req_*                          core request (valid/ready handshake)
//   rsp_valid_o/rdata_o/error_o    one-cycle response
//   wbAddress..wbDataWrite         transfer request to the master interface
//   wbDataRead, wbBusy             transfer completion from the master
module core_mem_access
    import core_mem_pkg::*;
(
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [27:0] req_addr_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_signed_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_error_o,
    output logic [27:0] wbAddress,
    output logic [3:0]  wbByteSelect,
    output logic        wbEnable,
    output logic        wbWriteEnable,
    output logic [31:0] wbDataWrite,
    input  logic [31:0] wbDataRead,
    input  logic        wbBusy
);

    state_e      state_q;
    logic        write_q;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [31:0] wdata_q;
    logic [31:0] low_q;

    logic [27:0] wb_addr_q;
    logic [3:0]  wb_sel_q;
    logic        wb_en_q;
    logic        wb_we_q;
    logic [31:0] wb_dw_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_error_q;

    logic [1:0]  al_off;
    logic [1:0]  al_size;
    logic        al_signed;
    logic [31:0] al_wdata;
    logic [31:0] al_low;
    logic [31:0] al_high;
    logic [6:0]  al_mask;
    logic [63:0] al_data64;
    logic        al_split;
    logic [31:0] al_rdata;

    // In IDLE the lane logic looks at the incoming request so the first
    // transfer can be registered on the accept edge; afterwards it uses the
    // latched fields. In WAIT2 the low word comes from the buffer and the
    // high word straight from the bus; otherwise the bus word is the low word.
    always_comb begin
        al_off    = off_q;
        al_size   = size_q;
        al_signed = signed_q;
        al_wdata  = wdata_q;
        al_low    = wbDataRead;
        al_high   = 32'h0;
        if (state_q == ST_IDLE) begin
            al_off    = req_addr_i[1:0];
            al_size   = req_size_i;
            al_signed = req_signed_i;
            al_wdata  = req_wdata_i;
        end
        if (state_q == ST_WAIT2) begin
            al_low  = low_q;
            al_high = wbDataRead;
        end
    end

    core_mem_align u_align (
        .off_i    (al_off),
        .size_i   (al_size),
        .signed_i (al_signed),
        .wdata_i  (al_wdata),
        .low_i    (al_low),
        .high_i   (al_high),
        .mask_o   (al_mask),
        .data64_o (al_data64),
        .split_o  (al_split),
        .rdata_o  (al_rdata)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q     <= ST_IDLE;
            write_q     <= 1'b0;
            off_q       <= 2'b0;
            size_q      <= 2'b0;
            signed_q    <= 1'b0;
            wdata_q     <= 32'h0;
            low_q       <= 32'h0;
            wb_addr_q   <= 28'h0;
            wb_sel_q    <= 4'h0;
            wb_en_q     <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_dw_q     <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_error_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        write_q  <= req_write_i;
                        off_q    <= req_addr_i[1:0];
                        size_q   <= req_size_i;
                        signed_q <= req_signed_i;
                        wdata_q  <= req_wdata_i;
                        if (req_size_i == SIZE_ILLEGAL) begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_error_q <= 1'b1;
                            rsp_rdata_q <= 32'h0;
                        end else begin
                            state_q   <= ST_ISSUE;
                            wb_en_q   <= 1'b1;
                            wb_addr_q <= {req_addr_i[27:2], 2'b00};
                            wb_sel_q  <= al_mask[3:0];
                            wb_we_q   <= req_write_i;
                            wb_dw_q   <= al_data64[31:0];
                        end
                    end
                end
                ST_ISSUE: begin
                    wb_en_q <= 1'b0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!wbBusy) begin
                        low_q <= wbDataRead;
                        if (al_split) begin
                            // Address wraps naturally in 28 bits.
                            state_q   <= ST_ISSUE2;
                            wb_en_q   <= 1'b1;
                            wb_addr_q <= wb_addr_q + 28'd4;
                            wb_sel_q  <= {1'b0, al_mask[6:4]};
                            wb_dw_q   <= al_data64[63:32];
                        end else begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= write_q ? 32'h0 : al_rdata;
                        end
                    end
                end
                ST_ISSUE2: begin
                    wb_en_q <= 1'b0;
                    state_q <= ST_WAIT2;
                end
                ST_WAIT2: begin
                    if (!wbBusy) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= write_q ? 32'h0 : al_rdata;
                    end
                end
                ST_RESP: begin
                    state_q     <= ST_IDLE;
                    rsp_valid_q <= 1'b0;
                    rsp_rdata_q <= 32'h0;
                    rsp_error_q <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready_o   = (state_q == ST_IDLE);
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_error_o   = rsp_error_q;
    assign wbAddress     = wb_addr_q;
    assign wbByteSelect  = wb_sel_q;
    assign wbEnable      = wb_en_q;
    assign wbWriteEnable = wb_we_q;
    assign wbDataWrite   = wb_dw_q;

endmodule

// File: doc/core_mem_access.md
# core_mem_access

Load/store front end of the ExperiarCore data path. Accepts byte, halfword and word requests at any byte address from the core pipeline and converts them into word-aligned single transfers on the core-side memory port of the core Wishbone master interface. Misaligned requests that straddle a word boundary are split into two back-to-back transfers. Read data is recombined, zero- or sign-extended and returned with a one-cycle response pulse.

## Interface
- No parameters; address width is fixed at 28 bits, data width at 32.
- wb_clk_i  in  1  sole clock.
- wb_rst_n_i  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  core request valid.
- req_ready_o  out  1  request accepted when valid & ready.
- req_write_i  in  1  1 = store, 0 = load.
- req_addr_i  in  28  byte address.
- req_size_i  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_signed_i  in  1  sign-extend load result.
- req_wdata_i  in  32  store data, right-justified.
- rsp_valid_o  out  1  one-cycle response pulse.
- rsp_rdata_o  out  32  load result; 0 for stores and errors.
- rsp_error_o  out  1  illegal size, qualified by rsp_valid_o.
- wbAddress  out  28  word-aligned byte address, bits [1:0] = 0.
- wbByteSelect  out  4  byte lanes.
- wbEnable  out  1  transfer start, single-cycle.
- wbWriteEnable  out  1  transfer is a write.
- wbDataWrite  out  32  lane-positioned store data.
- wbDataRead  in  32  read data from the master interface.
- wbBusy  in  1  master interface transfer in flight.

## Operation
- States: IDLE, ISSUE, WAIT, ISSUE2, WAIT2, RESP.
- IDLE: req_ready_o = 1. On accept, latch all request fields. Size 3 goes to RESP with error and makes no bus access. Otherwise go to ISSUE.
- Lane math: off = addr[1:0]; mask = {1,3,15}[size] << off, 7 bits; data64 = wdata << 8*off.
- First transfer: address {addr[27:2],00}, sel mask[3:0], data data64[31:0].
- Second transfer: needed iff mask[6:4] != 0. Address = first + 4, wrapping mod 2^28. Sel {1'b0,mask[6:4]}, data data64[63:32].
- ISSUE/ISSUE2: wbEnable = 1 for exactly one cycle, then go to WAIT/WAIT2.
- WAIT/WAIT2: wbBusy is high on entry. The first cycle with wbBusy = 0 captures wbDataRead into the low/high word buffer. WAIT then goes to ISSUE2 if split, else RESP; WAIT2 goes to RESP.
- wbEnable is never asserted while the master is in its end cycle; the ISSUE2 transfer starts one cycle after capture.
- wbAddress, wbByteSelect, wbWriteEnable and wbDataWrite are held stable from ISSUE through the end of WAIT, and likewise for ISSUE2/WAIT2.
- RESP: rsp_valid_o = 1 for one cycle, then IDLE.
- Load result: {high, low} >> 8*off, truncated to size. Sign-extend when req_signed_i = 1, otherwise zero-extend. Loads ignore the high buffer when the access is not split.
- Bus error: the master ends the transfer early and the data read back is 0xFFFFFFFF. That value passes through the recombination unchanged, and rsp_error_o stays 0.
- All outputs reset to 0, except req_ready_o, which is 1 in IDLE after reset. Asynchronous reset mid-transfer returns to IDLE. The master interface must be reset in the same cycle.

## Timing
- Aligned access with immediate ack: accept at T0, ISSUE at T1, WAIT at T2–T3 (capture at T3), rsp_valid_o at T4.
- Split access: ISSUE2 at T4, WAIT2 at T5–T6, rsp_valid_o at T7.
- Each extra ack wait state adds one cycle per transfer.
- Illegal size: accept at T0, rsp_valid_o at T1.
- No new request is accepted before the RESP cycle completes.

## Structure
- Package core_mem_pkg holds the size encodings (SIZE_BYTE/HALF/WORD), the state localparams and the lane-mask constants.
- Sub-module core_mem_align: combinational block computing mask, data64, second-transfer need and the load extract/extend. The FSM and buffers stay in core_mem_access.

## Test plan
- Signed byte load at 0x0000003, memory word 0x80112233: one transfer, address 0x0000000, sel 1000; rsp_rdata_o = 0xFFFFFF80 at T4.
- Word store 0xAABBCCDD at 0x0000006:
  - first transfer: address 0x0000004, sel 1100, data 0xCCDD0000;
  - second transfer: address 0x0000008, sel 0011, data 0x0000AABB;
  - rsp_valid_o at T7.
- Half load at 0x0000003, words 0x11223344 and 0x55667788: unsigned gives 0x00008811; signed gives 0xFFFF8811.
- Word load at 0xFFFFFFE: second transfer address wraps to 0x0000000; wbEnable is never asserted during the master's end cycle.
- Size 3 request: no wbEnable; rsp_error_o = 1 and rsp_rdata_o = 0 at T1.
- wb_rst_n_i low during WAIT2: wbEnable = 0 and req_ready_o = 1 after release; the next aligned read completes normally.
